shift_reg_window: RTL and testbench
===================================

Name: shift_reg_window

Overview:
- Streaming sliding-window generator for raster-scan pixel streams.
- Accepts one pixel per enabled clock, buffers (block_height-1) full lines plus block_width pixels, and presents a block_width × block_height neighbourhood every cycle as a flat bus.
- Sits between a pixel source (BMP stream reader or an upstream filter) and neighbourhood operators: box low-pass, 3x3 local-extremum compare, convolution.

Parameters:
- pixel_depth, 8, bits per pixel.
- frame_width, 200, pixels per image line; the vertical tap distance.
- block_width, 3, window columns; legal range 1..frame_width.
- block_height, 3, window rows; legal range ≥1.

Ports:
- clk  input  1  pixel clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  shift enable; one pixel accepted per rising edge while high.
- pixel_in  input  pixel_depth  incoming pixel, raster order.
- window_out  output  pixel_depth*block_width*block_height  flattened window.

Behaviour:
- Reset:
  - rst is asynchronous and active-high; the clock is a single domain.
  - While rst is high, every storage element is 0, so window_out is all zeros.
  - rst asserted mid-stream discards all buffered pixels immediately, without waiting for a clock edge.
  - After release, the first enabled edge loads pixel_in into element 0; all other elements stay 0 until filled.
- Storage:
  - A linear delay line of depth L = frame_width*(block_height-1)+block_width pixels.
  - On a rising edge with en=1 and rst=0, every stage shifts by one and pixel_in enters stage 0.
  - With en=0, contents hold; window_out is unchanged.
- Window mapping:
  - Element index k = r*block_width + c, with r in 0..block_height-1 and c in 0..block_width-1.
  - Element k occupies window_out[k*pixel_depth +: pixel_depth].
  - Element k = delay-line stage r*frame_width + c, i.e. the pixel accepted r*frame_width+c enabled clocks ago.
  - Element 0 is the newest pixel (bottom-right of the image window).
  - The last element is the oldest (top-left).
  - For odd sizes, the centre element is index (block_height/2)*block_width + block_width/2. For 3x3 this is index 4.
- Latency:
  - window_out is registered, with zero extra pipeline.
  - A pixel sampled at edge t is visible at element 0 immediately after edge t.
  - It is visible at element k after k' further enabled edges, where k' = r*frame_width+c.
- Boundaries:
  - No edge padding or line-wrap masking.
  - Windows straddling a line boundary contain the tail of the previous line.
  - Windows at the top of the frame contain reset zeros or the previous frame's data.
  - Consumers handle borders.
- Arithmetic: none; data passes bit-exact, unsigned or signed alike.
- Output logic: window_out is driven purely from flops, with no combinational path from pixel_in.
- Reset style: every stage uses async-reset flops; inferred RAM is not permitted.

Test Plan:
- Reset hold: rst=1 with en=1 and pixel_in=8'hAA toggling for 5 clocks -> window_out==0 throughout.
  - Release rst and push one pixel 8'h37 -> element0=8'h37, all others 0.
- Ramp fill (default params): push pixel value n&8'hFF for n=0..402 (403 enabled clocks).
  - Required: element0=146, element1=145, element2=144, element3=(402-200)&255=202, element4=201, element8=0.
- Enable gating: after the ramp, hold en=0 for 10 clocks with random pixel_in -> window_out bit-identical to its pre-hold value.
  - Next enabled push of 8'hFF -> element0=255, element1=146, element4=202.
- Async reset mid-stream: assert rst between clock edges after 250 pushes.
  - window_out==0 before the next rising edge.
  - Stays 0 until the first enabled edge after release.
- Parameter sweep:
  - pixel_depth=12, frame_width=16, block_width=5, block_height=5, ramp input n&12'hFFF for 100 pushes.
  - Required: element k(r,c) = 99 - (r*16+c) for all 25 elements.
- Degenerate 1x1: block_width=1, block_height=1 -> window_out equals the last enabled pixel_in (single register).

Source files
------------

// File: rtl/shift_reg_window.sv
// Sliding-window generator for raster-scan pixel streams: a flop-based delay line
// spanning (block_height-1) lines plus block_width pixels, tapped into a flat window bus.
module shift_reg_window #(
    parameter int pixel_depth  = 8,
    parameter int frame_width  = 200,
    parameter int block_width  = 3,
    parameter int block_height = 3
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic [pixel_depth-1:0]                        pixel_in,
    output logic [pixel_depth*block_width*block_height-1:0] window_out
);

    localparam int LINE_DEPTH = frame_width * (block_height - 1) + block_width;

    logic [pixel_depth-1:0] line_q [LINE_DEPTH];
    logic [pixel_depth-1:0] line_d [LINE_DEPTH];

    // Next-state of the delay line: shift by one stage on an enabled clock, else hold.
    always_comb begin
        line_d = line_q;
        if (en) begin
            line_d[0] = pixel_in;
            for (int i = 1; i < LINE_DEPTH; i++) begin
                line_d[i] = line_q[i - 1];
            end
        end else begin
            line_d = line_q;
        end
    end

    // Delay-line storage; every stage clears asynchronously so no RAM is inferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINE_DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            line_q <= line_d;
        end
    end

    // Element k = r*block_width + c taps stage r*frame_width + c; pure wiring from flops.
    for (genvar r = 0; r < block_height; r++) begin : g_row
        for (genvar c = 0; c < block_width; c++) begin : g_col
            assign window_out[(r*block_width + c)*pixel_depth +: pixel_depth] =
                line_q[r*frame_width + c];
        end
    end

endmodule

// File: tb/tb_shift_reg_window.sv
// Directed + randomized bench for shift_reg_window; three instances cover the default
// 3x3 window, a 12-bit 5x5 window on 16-pixel lines, and the degenerate 1x1 case.
module tb_shift_reg_window;

    localparam int PD_A = 8;
    localparam int FW_A = 200;
    localparam int BW_A = 3;
    localparam int BH_A = 3;
    localparam int LA   = FW_A*(BH_A-1) + BW_A;

    localparam int PD_B = 12;
    localparam int FW_B = 16;
    localparam int BW_B = 5;
    localparam int BH_B = 5;
    localparam int LB   = FW_B*(BH_B-1) + BW_B;

    logic clk = 1'b0;
    logic rst;
    logic en_a;
    logic en_b;
    logic [PD_A-1:0] pix_a;
    logic [PD_B-1:0] pix_b;
    logic [PD_A*BW_A*BH_A-1:0] win_a;
    logic [PD_B*BW_B*BH_B-1:0] win_b;
    logic [PD_A-1:0] win_c;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: newest pixel at index 0, truncated to the delay-line depth.
    logic [PD_A-1:0] hist_a [$];
    logic [PD_B-1:0] hist_b [$];
    logic [PD_A-1:0] last_c;
    logic [PD_A*BW_A*BH_A-1:0] snap_a;

    shift_reg_window #(.pixel_depth(PD_A), .frame_width(FW_A), .block_width(BW_A), .block_height(BH_A)) u_dut_a (
        .clk(clk), .rst(rst), .en(en_a), .pixel_in(pix_a), .window_out(win_a));

    shift_reg_window #(.pixel_depth(PD_B), .frame_width(FW_B), .block_width(BW_B), .block_height(BH_B)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .pixel_in(pix_b), .window_out(win_b));

    shift_reg_window #(.pixel_depth(PD_A), .frame_width(FW_A), .block_width(1), .block_height(1)) u_dut_c (
        .clk(clk), .rst(rst), .en(en_a), .pixel_in(pix_a), .window_out(win_c));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PD_A-1:0] ref_a(input int k);
        int idx;
        idx = (k / BW_A) * FW_A + (k % BW_A);
        return (idx < hist_a.size()) ? hist_a[idx] : 8'h00;
    endfunction

    function automatic logic [PD_B-1:0] ref_b(input int k);
        int idx;
        idx = (k / BW_B) * FW_B + (k % BW_B);
        return (idx < hist_b.size()) ? hist_b[idx] : 12'h000;
    endfunction

    task automatic clear_model();
        hist_a.delete();
        hist_b.delete();
        last_c = 8'h00;
    endtask

    task automatic push_a(input logic [PD_A-1:0] v);
        pix_a = v;
        en_a  = 1'b1;
        @(posedge clk);
        #1;
        en_a  = 1'b0;
        hist_a.push_front(v);
        if (hist_a.size() > LA) void'(hist_a.pop_back());
        last_c = v;
    endtask

    task automatic push_b(input logic [PD_B-1:0] v);
        pix_b = v;
        en_b  = 1'b1;
        @(posedge clk);
        #1;
        en_b  = 1'b0;
        hist_b.push_front(v);
        if (hist_b.size() > LB) void'(hist_b.pop_back());
    endtask

    task automatic check_a(input string tag);
        for (int k = 0; k < BW_A*BH_A; k++) begin
            check($sformatf("%s_a_e%0d", tag, k), {24'd0, win_a[k*PD_A +: PD_A]}, {24'd0, ref_a(k)});
        end
        check($sformatf("%s_c", tag), {24'd0, win_c}, {24'd0, last_c});
    endtask

    task automatic check_b(input string tag);
        for (int k = 0; k < BW_B*BH_B; k++) begin
            check($sformatf("%s_b_e%0d", tag, k), {20'd0, win_b[k*PD_B +: PD_B]}, {20'd0, ref_b(k)});
        end
    endtask

    task automatic check_zero(input string tag);
        check($sformatf("%s_a_zero", tag), {31'd0, (win_a === '0)}, 32'd1);
        check($sformatf("%s_b_zero", tag), {31'd0, (win_b === '0)}, 32'd1);
        check($sformatf("%s_c_zero", tag), {31'd0, (win_c === '0)}, 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        en_a  = 1'b0;
        en_b  = 1'b0;
        pix_a = 8'h00;
        pix_b = 12'h000;
        clear_model();
        repeat (2) @(posedge clk);
        #1;

        // Reset hold with enable high and toggling input.
        en_a = 1'b1;
        en_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pix_a = (i % 2 == 0) ? 8'hAA : 8'h55;
            pix_b = (i % 2 == 0) ? 12'hAAA : 12'h555;
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        en_a = 1'b0;
        en_b = 1'b0;
        #2;
        rst = 1'b0;
        #2;

        // First pixel after release.
        push_a(8'h37);
        check("first_e0", {24'd0, win_a[7:0]}, 32'h37);
        check("first_rest_zero", {31'd0, (win_a[PD_A*BW_A*BH_A-1:8] === '0)}, 32'd1);
        check_a("first");

        // Ramp fill: 403 pushes of n & 8'hFF.
        for (int n = 0; n <= 402; n++) begin
            push_a(8'(n));
        end
        check("ramp_e0", {24'd0, win_a[0*8 +: 8]}, 32'd146);
        check("ramp_e1", {24'd0, win_a[1*8 +: 8]}, 32'd145);
        check("ramp_e2", {24'd0, win_a[2*8 +: 8]}, 32'd144);
        check("ramp_e3", {24'd0, win_a[3*8 +: 8]}, 32'd202);
        check("ramp_e4", {24'd0, win_a[4*8 +: 8]}, 32'd201);
        check("ramp_e8", {24'd0, win_a[8*8 +: 8]}, 32'd0);
        check_a("ramp");

        // Enable gating: window must not move while en is low.
        snap_a = win_a;
        for (int i = 0; i < 10; i++) begin
            pix_a = 8'($urandom);
            en_a  = 1'b0;
            @(posedge clk);
            #1;
            check("hold_a", {31'd0, (win_a === snap_a)}, 32'd1);
        end
        check_a("hold_end");
        push_a(8'hFF);
        check("gate_e0", {24'd0, win_a[0*8 +: 8]}, 32'd255);
        check("gate_e1", {24'd0, win_a[1*8 +: 8]}, 32'd146);
        check("gate_e4", {24'd0, win_a[4*8 +: 8]}, 32'd202);
        check_a("gate");

        // Random stream, then asynchronous reset between clock edges.
        for (int i = 0; i < 250; i++) begin
            push_a(8'($urandom));
            if (i % 50 == 49) check_a("rand");
        end
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        clear_model();
        en_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix_a = 8'($urandom);
            @(posedge clk);
            #1;
            check_zero("async_hold");
        end
        en_a = 1'b0;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pix_a = 8'($urandom);
            @(posedge clk);
            #1;
            check_zero("post_release");
        end
        push_a(8'($urandom));
        check_a("after_release");

        // 12-bit 5x5 sweep on 16-pixel lines.
        for (int n = 0; n < 100; n++) begin
            push_b(12'(n));
        end
        for (int r = 0; r < BH_B; r++) begin
            for (int c = 0; c < BW_B; c++) begin
                check($sformatf("sweep_r%0d_c%0d", r, c),
                      {20'd0, win_b[(r*BW_B + c)*PD_B +: PD_B]}, 32'(99 - (r*FW_B + c)));
            end
        end
        for (int i = 0; i < 40; i++) begin
            push_b(12'($urandom));
            push_a(8'($urandom));
        end
        check_b("sweep_rand");
        check_a("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
